// File: rtl/video_pattern_gen.sv
// Pixel-stream source: programmable raster timing with bars/gradient/checker/solid test patterns.
// Optional VIDEO_GEN_SCROLL_EN adds a frame counter (oFrameCount) that scrolls gradient/checker.
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iEnable,
  input  logic [1:0]  iPattern,
  input  logic [23:0] iSolid,
  output logic [7:0]  oR,
  output logic [7:0]  oG,
  output logic [7:0]  oB,
  output logic        oHSync,
  output logic        oVSync,
  output logic        oLineValid,
  output logic        oFrameValid,
  output logic [11:0] oX,
  output logic [11:0] oY,
  output logic        oFrameDone
`ifdef VIDEO_GEN_SCROLL_EN
  ,
  output logic [7:0]  oFrameCount
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT    = 12'(V_ACTIVE);
  localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_START = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

  typedef enum logic [1:0] {IDLE, RUN, STOP_PENDING} state_t;

  state_t         state, stateNext;
  logic [11:0]    hCnt, hNext, hAdv;
  logic [11:0]    vCnt, vNext, vAdv;
  logic [BW-1:0]  barCnt, barCntNext, barCntAdv;
  logic [2:0]     barIdx, barIdxNext, barIdxAdv;
  logic [1:0]     patReg;
  logic [23:0]    solidReg;
  logic           latch, advance, lastPixel, running;
  logic [7:0]     hScroll;

  logic           lineValid, frameValid, hSyncN, vSyncN;
  logic [23:0]    barRgb, pixRgb;

  assign lastPixel = (hCnt == H_LAST) && (vCnt == V_LAST);
  assign running   = (state != IDLE);

  // Counter advance; the bar sub-counter tracks h so bar selection needs no divider.
  always_comb begin
    hAdv      = hCnt + 12'd1;
    vAdv      = vCnt;
    barCntAdv = barCnt + BW'(1);
    barIdxAdv = barIdx;
    if (hCnt == H_LAST) begin
      hAdv      = '0;
      barCntAdv = '0;
      barIdxAdv = '0;
      vAdv      = (vCnt == V_LAST) ? 12'd0 : vCnt + 12'd1;
    end else if (barCnt == BAR_LAST) begin
      barCntAdv = '0;
      barIdxAdv = barIdx + 3'd1;
    end
  end

  always_comb begin
    stateNext  = state;
    hNext      = hCnt;
    vNext      = vCnt;
    barCntNext = barCnt;
    barIdxNext = barIdx;
    latch      = 1'b0;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (iEnable) begin
          stateNext = RUN;
          latch     = 1'b1;
        end
      end
      RUN: begin
        advance = 1'b1;
        if (!iEnable) stateNext = STOP_PENDING;
      end
      STOP_PENDING: begin
        if (iEnable) begin
          stateNext = RUN;
          advance   = 1'b1;
        end else if (lastPixel) begin
          stateNext  = IDLE;
          hNext      = '0;
          vNext      = '0;
          barCntNext = '0;
          barIdxNext = '0;
        end else begin
          advance = 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
    if (advance) begin
      hNext      = hAdv;
      vNext      = vAdv;
      barCntNext = barCntAdv;
      barIdxNext = barIdxAdv;
      latch      = lastPixel;
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state    <= IDLE;
      hCnt     <= '0;
      vCnt     <= '0;
      barCnt   <= '0;
      barIdx   <= '0;
      patReg   <= '0;
      solidReg <= '0;
    end else begin
      state  <= stateNext;
      hCnt   <= hNext;
      vCnt   <= vNext;
      barCnt <= barCntNext;
      barIdx <= barIdxNext;
      if (latch) begin
        patReg   <= iPattern;
        solidReg <= iSolid;
      end
    end
  end

`ifdef VIDEO_GEN_SCROLL_EN
  logic [7:0] fcReg;

  // Advances together with the oFrameDone pulse so the next frame's first pixel sees the new value.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) fcReg <= '0;
    else if (running && lastPixel) fcReg <= fcReg + 8'd1;
  end

  assign oFrameCount = fcReg;
  assign hScroll     = hCnt[7:0] + fcReg;
`else
  assign hScroll = hCnt[7:0];
`endif

  always_comb begin
    lineValid  = (hCnt < H_ACT) && (vCnt < V_ACT);
    frameValid = (vCnt < V_ACT);
    hSyncN     = !((hCnt >= HS_START) && (hCnt < HS_END));
    vSyncN     = !((vCnt >= VS_START) && (vCnt < VS_END));
    // Bar order white..black maps onto inverted index bits: R=~b1, G=~b2, B=~b0.
    barRgb = {{8{~barIdx[1]}}, {8{~barIdx[2]}}, {8{~barIdx[0]}}};
    case (patReg)
      2'd0:    pixRgb = barRgb;
      2'd1:    pixRgb = {hScroll, vCnt[7:0], hCnt[7:0] + vCnt[7:0]};
      2'd2:    pixRgb = (hScroll[5] ^ vCnt[5]) ? 24'hFFFFFF : 24'h000000;
      default: pixRgb = solidReg;
    endcase
    if (!lineValid) pixRgb = '0;
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oFrameDone  <= 1'b0;
    end else if (running) begin
      {oR, oG, oB} <= pixRgb;
      oHSync       <= hSyncN;
      oVSync       <= vSyncN;
      oLineValid   <= lineValid;
      oFrameValid  <= frameValid;
      oX           <= hCnt;
      oY           <= vCnt;
      oFrameDone   <= lastPixel;
    end else begin
      oR          <= '0;
      oG          <= '0;
      oB          <= '0;
      oHSync      <= 1'b1;
      oVSync      <= 1'b1;
      oLineValid  <= 1'b0;
      oFrameValid <= 1'b0;
      oX          <= '0;
      oY          <= '0;
      oFrameDone  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 14x7 raster (8x4 active).
// Builds with or without VIDEO_GEN_SCROLL_EN.
module tb_video_pattern_gen;

  localparam int H_ACTIVE = 8;
  localparam int H_FP     = 2;
  localparam int H_SYNC   = 2;
  localparam int H_BP     = 2;
  localparam int V_ACTIVE = 4;
  localparam int V_FP     = 1;
  localparam int V_SYNC   = 1;
  localparam int V_BP     = 1;
  localparam int HT       = 14;
  localparam int VT       = 7;
  localparam int FRAME    = HT * VT;
`ifdef VIDEO_GEN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iEnable = 1'b0;
  logic [1:0]  iPattern = 2'd0;
  logic [23:0] iSolid = 24'h0;
  logic [7:0]  oR, oG, oB;
  logic        oHSync, oVSync, oLineValid, oFrameValid, oFrameDone;
  logic [11:0] oX, oY;
`ifdef VIDEO_GEN_SCROLL_EN
  logic [7:0]  oFrameCount;
`endif

  int checks = 0;
  int errors = 0;

  always #5 iClk = ~iClk;

  video_pattern_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iPattern(iPattern), .iSolid(iSolid),
    .oR(oR), .oG(oG), .oB(oB), .oHSync(oHSync), .oVSync(oVSync),
    .oLineValid(oLineValid), .oFrameValid(oFrameValid), .oX(oX), .oY(oY),
    .oFrameDone(oFrameDone)
`ifdef VIDEO_GEN_SCROLL_EN
    , .oFrameCount(oFrameCount)
`endif
  );

  // {RGB, HSync, VSync, LineValid, FrameValid, X, Y, FrameDone}
  logic [52:0] obs;
  assign obs = {oR, oG, oB, oHSync, oVSync, oLineValid, oFrameValid, oX, oY, oFrameDone};
  localparam logic [52:0] IDLE_VEC = {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0, 12'd0, 1'b0};

  function automatic logic [23:0] barColour(input int i);
    case (i)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  function automatic logic [52:0] expPix(input int h, input int v, input int pat,
                                         input logic [23:0] solid, input int fc, input logic fd);
    logic lv, fv, hs, vs;
    logic [23:0] rgb;
    int hsc;
    lv  = (h < H_ACTIVE) && (v < V_ACTIVE);
    fv  = (v < V_ACTIVE);
    hs  = !((h >= H_ACTIVE + H_FP) && (h < H_ACTIVE + H_FP + H_SYNC));
    vs  = !((v >= V_ACTIVE + V_FP) && (v < V_ACTIVE + V_FP + V_SYNC));
    hsc = h + SCROLL * fc;
    rgb = 24'h0;
    if (lv) begin
      case (pat)
        0: rgb = barColour(h / (H_ACTIVE / 8));
        1: rgb = {8'(hsc), 8'(v), 8'(h + v)};
        2: rgb = ((((hsc >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
        default: rgb = solid;
      endcase
    end
    return {rgb, hs, vs, lv, fv, 12'(h), 12'(v), fd};
  endfunction

  // Resets the DUT and starts it; the next negedge shows pixel (0,0).
  task automatic restart(input logic [1:0] pat, input logic [23:0] solid);
    @(negedge iClk);
    iEnable = 1'b0;
    iRst    = 1'b1;
    @(negedge iClk);
    iRst     = 1'b0;
    iPattern = pat;
    iSolid   = solid;
    iEnable  = 1'b1;
    @(negedge iClk);
  endtask

  task automatic test_reset();
    logic [52:0] e;
    iRst = 1'b1;
    repeat (2) @(negedge iClk);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL reset_values got %h expected %h", obs, IDLE_VEC);
    end
    iRst = 1'b0;
    repeat (3) @(negedge iClk);
    e = IDLE_VEC;
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL idle_hold got %h expected %h", obs, e);
    end
    $display("test_reset: done");
  endtask

  task automatic test_timing_bars();
    logic [52:0] e;
    int p, lvCount, fdCount;
    lvCount = 0;
    fdCount = 0;
    restart(2'd0, 24'h0);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL first_pixel_early got %h expected %h", obs, IDLE_VEC);
    end
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge iClk);
      p = k % FRAME;
      e = expPix(p % HT, p / HT, 0, 24'h0, k / FRAME, p == FRAME - 1);
      if (oLineValid) lvCount++;
      if (oFrameDone) fdCount++;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL timing_bars k=%0d got %h expected %h", k, obs, e);
      end
    end
    checks++;
    if (lvCount !== 2 * H_ACTIVE * V_ACTIVE || fdCount !== 2) begin
      errors++;
      $display("FAIL valid_counts got lv=%0d fd=%0d expected lv=%0d fd=2", lvCount, fdCount,
               2 * H_ACTIVE * V_ACTIVE);
    end
    $display("test_timing_bars: %0d pixels", 2 * FRAME);
  endtask

  task automatic test_pattern_latch();
    logic [52:0] e;
    int p, pat;
    restart(2'd3, 24'h123456);
    for (int k = 0; k < FRAME + HT + 6; k++) begin
      @(negedge iClk);
      p   = k % FRAME;
      pat = (k < FRAME) ? 3 : 1;
      e   = expPix(p % HT, p / HT, pat, 24'h123456, k / FRAME, p == FRAME - 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pattern_latch k=%0d got %h expected %h", k, obs, e);
      end
      if (k == 2 * HT + 3) iPattern = 2'd1;
    end
    $display("test_pattern_latch: pattern switched at (3,2)");
  endtask

  task automatic test_stop();
    logic [52:0] e;
    int p;
    restart(2'd0, 24'h0);
    for (int k = 0; k < FRAME + 10; k++) begin
      @(negedge iClk);
      p = k % FRAME;
      e = (k < FRAME) ? expPix(p % HT, p / HT, 0, 24'h0, 0, p == FRAME - 1) : IDLE_VEC;
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL stop k=%0d got %h expected %h", k, obs, e);
      end
      if (k == HT + 4) iEnable = 1'b0;
    end
    $display("test_stop: frame completed then idle");
  endtask

  task automatic test_back_to_back();
    logic [52:0] e;
    int p;
    restart(2'd0, 24'h0);
    for (int k = 0; k < FRAME + 2 * HT; k++) begin
      @(negedge iClk);
      p = k % FRAME;
      e = expPix(p % HT, p / HT, 0, 24'h0, k / FRAME, p == FRAME - 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL back_to_back k=%0d got %h expected %h", k, obs, e);
      end
      if (k == HT + 4) iEnable = 1'b0;
      if (k == 40) iEnable = 1'b1;
    end
    $display("test_back_to_back: no gap between frames");
  endtask

  task automatic test_reset_midframe();
    logic [52:0] e;
    restart(2'd0, 24'h0);
    for (int k = 0; k <= 2 * HT + 6; k++) begin
      @(negedge iClk);
      e = expPix(k % HT, k / HT, 0, 24'h0, 0, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL pre_reset k=%0d got %h expected %h", k, obs, e);
      end
    end
    iRst = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL async_reset got %h expected %h", obs, IDLE_VEC);
    end
    @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    checks++;
    if (obs !== IDLE_VEC) begin
      errors++;
      $display("FAIL restart_gap got %h expected %h", obs, IDLE_VEC);
    end
    for (int k = 0; k < HT; k++) begin
      @(negedge iClk);
      e = expPix(k % HT, k / HT, 0, 24'h0, 0, 1'b0);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL post_reset k=%0d got %h expected %h", k, obs, e);
      end
    end
    $display("test_reset_midframe: restarted from (0,0)");
  endtask

`ifdef VIDEO_GEN_SCROLL_EN
  task automatic test_scroll();
    logic [52:0] e;
    int p;
    restart(2'd1, 24'h0);
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge iClk);
      p = k % FRAME;
      e = expPix(p % HT, p / HT, 1, 24'h0, k / FRAME, p == FRAME - 1);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL scroll_pixel k=%0d got %h expected %h", k, obs, e);
      end
      if (p == 0) begin
        checks++;
        if (oFrameCount !== 8'(k / FRAME)) begin
          errors++;
          $display("FAIL frame_count k=%0d got %0d expected %0d", k, oFrameCount, k / FRAME);
        end
      end
    end
    $display("test_scroll: 3 frames");
  endtask
`endif

  initial begin
    test_reset();
    test_timing_bars();
    test_pattern_latch();
    test_stop();
    test_back_to_back();
    test_reset_midframe();
`ifdef VIDEO_GEN_SCROLL_EN
    test_scroll();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
